// File: rtl/decode_tbdec_pkg.sv
// Shared names and constants for the Time Base / Decrementer block.
// Holds the DE_spr_* encodings it decodes, reset constants and the write-target decode helper.
package decode_tbdec_pkg;

    localparam logic [5:0]  DE_spr_TBL = 6'h0C;
    localparam logic [5:0]  DE_spr_TBU = 6'h0D;
    localparam logic [5:0]  DE_spr_DEC = 6'h16;

    localparam logic [31:0] TBDEC_DEC_RESET_VAL    = 32'hFFFF_FFFF;
    localparam int          TBDEC_TB_PRESCALE_DEF  = 1;
    localparam int          TBDEC_PRESCALE_W_DEF   = 8;

    typedef enum logic [1:0] {
        WR_NONE = 2'd0,
        WR_TBL  = 2'd1,
        WR_TBU  = 2'd2,
        WR_DEC  = 2'd3
    } tbdec_wr_e;

    // Only the three timer SPRs are claimed; every other name belongs to the SPR file.
    function automatic tbdec_wr_e tbdec_wr_decode(input logic en, input logic [5:0] name);
        tbdec_wr_e sel;
        sel = WR_NONE;
        if (en) begin
            case (name)
                DE_spr_TBL: sel = WR_TBL;
                DE_spr_TBU: sel = WR_TBU;
                DE_spr_DEC: sel = WR_DEC;
                default:    sel = WR_NONE;
            endcase
        end
        return sel;
    endfunction

endpackage

// File: rtl/tbdec_prescaler.sv
// Free-running prescaler: counts 0..TB_PRESCALE-1 and pulses tick on the last count.
// Combinational tick from a registered count; freeze holds the count and masks the tick.
module tbdec_prescaler #(
    parameter int TB_PRESCALE = 1,
    parameter int PRESCALE_W  = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic freeze,
    output logic tick
);

    localparam logic [PRESCALE_W-1:0] LAST_CNT = PRESCALE_W'(TB_PRESCALE - 1);

    logic [PRESCALE_W-1:0] cnt_q;
    logic [PRESCALE_W-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST_CNT) && !freeze;
        cnt_d = cnt_q;
        if (!freeze) begin
            cnt_d = tick ? '0 : cnt_q + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/decode_tbdec.sv
// Architected Time Base (64b) and Decrementer (32b) with SPR write port and level dec_irq.
// Writes visible 1 cycle after strobe; TBDEC_MTDEC_IRQ_EN lets DEC writes raise dec_irq.
module decode_tbdec
    import decode_tbdec_pkg::*;
#(
    parameter int TB_PRESCALE = TBDEC_TB_PRESCALE_DEF,
    parameter int PRESCALE_W  = TBDEC_PRESCALE_W_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_spr_en,
    input  logic [5:0]  wr_spr_name,
    input  logic [31:0] wr_spr_value,
    input  logic        tb_freeze,
    output logic [63:0] as_TB,
    output logic [31:0] as_DEC,
    output logic        dec_irq,
    input  logic        dec_irq_ack
);

    logic        tick;
    tbdec_wr_e   wr_sel;
    logic        lo_carry;
    logic        irq_set;

    logic [31:0] tb_lo_q, tb_lo_d;
    logic [31:0] tb_hi_q, tb_hi_d;
    logic [31:0] dec_q, dec_d;
    logic        dec_irq_q, dec_irq_d;

    tbdec_prescaler #(
        .TB_PRESCALE (TB_PRESCALE),
        .PRESCALE_W  (PRESCALE_W)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .freeze  (tb_freeze),
        .tick    (tick)
    );

    always_comb begin
        wr_sel   = tbdec_wr_decode(wr_spr_en, wr_spr_name);
        lo_carry = tick && (tb_lo_q == 32'hFFFF_FFFF);

        tb_lo_d  = tick ? tb_lo_q + 32'd1 : tb_lo_q;
        tb_hi_d  = lo_carry ? tb_hi_q + 32'd1 : tb_hi_q;
        dec_d    = tick ? dec_q - 32'd1 : dec_q;
        // Only the 0 -> FFFF_FFFF decrement flips DEC[31] from 0 to 1.
        irq_set  = tick && (dec_q == 32'd0);

        // A write overrides only its own field; carry into an overwritten TBU is lost.
        case (wr_sel)
            WR_TBL: begin
                tb_lo_d = wr_spr_value;
                tb_hi_d = tb_hi_q;
            end
            WR_TBU: begin
                tb_hi_d = wr_spr_value;
            end
            WR_DEC: begin
                dec_d = wr_spr_value;
`ifdef TBDEC_MTDEC_IRQ_EN
                irq_set = wr_spr_value[31] && !dec_q[31];
`else
                irq_set = 1'b0;
`endif
            end
            default: begin
            end
        endcase

        if (irq_set) begin
            dec_irq_d = 1'b1;
        end else if (dec_irq_ack) begin
            dec_irq_d = 1'b0;
        end else begin
            dec_irq_d = dec_irq_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tb_lo_q   <= '0;
            tb_hi_q   <= '0;
            dec_q     <= TBDEC_DEC_RESET_VAL;
            dec_irq_q <= 1'b0;
        end else begin
            tb_lo_q   <= tb_lo_d;
            tb_hi_q   <= tb_hi_d;
            dec_q     <= dec_d;
            dec_irq_q <= dec_irq_d;
        end
    end

    assign as_TB   = {tb_hi_q, tb_lo_q};
    assign as_DEC  = dec_q;
    assign dec_irq = dec_irq_q;

endmodule

// File: tb/tb_decode_tbdec.sv
// Scoreboard bench: two instances (prescale 1 and 4) against a cycle-level reference model.
module tb_decode_tbdec;
    import decode_tbdec_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_spr_en = 1'b0;
    logic [5:0]  wr_spr_name = '0;
    logic [31:0] wr_spr_value = '0;
    logic        tb_freeze = 1'b0;
    logic        dec_irq_ack = 1'b0;

    logic [63:0] tb1, tb4;
    logic [31:0] dec1, dec4;
    logic        irq1, irq4;

    always #5 clk = ~clk;

    decode_tbdec #(.TB_PRESCALE(1), .PRESCALE_W(8)) dut1 (
        .clk(clk), .reset_n(reset_n), .wr_spr_en(wr_spr_en), .wr_spr_name(wr_spr_name),
        .wr_spr_value(wr_spr_value), .tb_freeze(tb_freeze), .as_TB(tb1), .as_DEC(dec1),
        .dec_irq(irq1), .dec_irq_ack(dec_irq_ack)
    );

    decode_tbdec #(.TB_PRESCALE(4), .PRESCALE_W(8)) dut4 (
        .clk(clk), .reset_n(reset_n), .wr_spr_en(wr_spr_en), .wr_spr_name(wr_spr_name),
        .wr_spr_value(wr_spr_value), .tb_freeze(tb_freeze), .as_TB(tb4), .as_DEC(dec4),
        .dec_irq(irq4), .dec_irq_ack(dec_irq_ack)
    );

    typedef struct packed {
        logic [63:0] tb;
        logic [31:0] dec;
        logic        irq;
    } obs_t;

    obs_t q1[$];
    obs_t q4[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: the architected values plus the number of enabled cycles into the period.
    logic [63:0] m_tb  [2];
    logic [31:0] m_dec [2];
    logic        m_irq [2];
    int          m_cnt [2];
    int          m_per [2] = '{1, 4};

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic        tk;
        logic [31:0] lo;
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                m_tb[i]  = 64'd0;
                m_dec[i] = 32'hFFFF_FFFF;
                m_irq[i] = 1'b0;
                m_cnt[i] = 0;
            end else begin
                tk = 1'b0;
                if (!tb_freeze) begin
                    m_cnt[i] = m_cnt[i] + 1;
                    if (m_cnt[i] == m_per[i]) begin
                        tk = 1'b1;
                        m_cnt[i] = 0;
                    end
                end
                lo = m_tb[i][31:0];
                if (wr_spr_en && wr_spr_name == DE_spr_TBL) begin
                    m_tb[i] = {m_tb[i][63:32], wr_spr_value};
                end else if (wr_spr_en && wr_spr_name == DE_spr_TBU) begin
                    m_tb[i] = {wr_spr_value, tk ? lo + 32'd1 : lo};
                end else if (tk) begin
                    m_tb[i] = m_tb[i] + 64'd1;
                end
                if (wr_spr_en && wr_spr_name == DE_spr_DEC) begin
`ifdef TBDEC_MTDEC_IRQ_EN
                    if (wr_spr_value[31] && !m_dec[i][31]) m_irq[i] = 1'b1;
                    else if (dec_irq_ack) m_irq[i] = 1'b0;
`else
                    if (dec_irq_ack) m_irq[i] = 1'b0;
`endif
                    m_dec[i] = wr_spr_value;
                end else if (tk && m_dec[i] == 32'd0) begin
                    m_dec[i] = 32'hFFFF_FFFF;
                    m_irq[i] = 1'b1;
                end else begin
                    if (tk) m_dec[i] = m_dec[i] - 32'd1;
                    if (dec_irq_ack) m_irq[i] = 1'b0;
                end
            end
        end
    endtask

    // One cycle: drive inputs on the falling edge and queue what the next rising edge must produce.
    task automatic step(input logic rst, input logic en, input logic [5:0] nm,
                        input logic [31:0] v, input logic frz, input logic ack);
        @(negedge clk);
        reset_n      = rst;
        wr_spr_en    = en;
        wr_spr_name  = nm;
        wr_spr_value = v;
        tb_freeze    = frz;
        dec_irq_ack  = ack;
        model_step();
        q1.push_back('{tb: m_tb[0], dec: m_dec[0], irq: m_irq[0]});
        q4.push_back('{tb: m_tb[1], dec: m_dec[1], irq: m_irq[1]});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 6'h00, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic wr(input logic [5:0] nm, input logic [31:0] v);
        step(1'b1, 1'b1, nm, v, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        obs_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q1.size() > 0) begin
                e = q1.pop_front();
                cmp("p1_tb", tb1, e.tb);
                cmp("p1_dec", {32'd0, dec1}, {32'd0, e.dec});
                cmp("p1_irq", {63'd0, irq1}, {63'd0, e.irq});
            end
            if (q4.size() > 0) begin
                e = q4.pop_front();
                cmp("p4_tb", tb4, e.tb);
                cmp("p4_dec", {32'd0, dec4}, {32'd0, e.dec});
                cmp("p4_irq", {63'd0, irq4}, {63'd0, e.irq});
            end
        end
    end

    initial begin : stim
        logic [31:0] v;
        logic [5:0]  nm;
        logic        rst_next;
        logic [31:0] irq_exp;

        step(1'b0, 1'b0, 6'h00, 32'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 6'h00, 32'd0, 1'b0, 1'b0);
        cmp("reset_tb", tb1, 64'd0);
        cmp("reset_dec", {32'd0, dec1}, 64'hFFFF_FFFF);
        cmp("reset_irq", {63'd0, irq1}, 64'd0);

        // Release and five ticks on the divide-by-1 instance.
        idle(6);
        cmp("five_ticks_tb", tb1, 64'd5);
        cmp("five_ticks_dec", {32'd0, dec1}, 64'hFFFF_FFFA);
        cmp("five_ticks_irq", {63'd0, irq1}, 64'd0);

        // TBL write colliding with the tick that would carry.
        wr(DE_spr_TBU, 32'h0000_0000);
        wr(DE_spr_TBL, 32'hFFFF_FFFE);
        idle(1);
        wr(DE_spr_TBL, 32'h0000_1234);
        idle(1);
        cmp("tbl_collide_tb", tb1, 64'h0000_0000_0000_1234);

        wr(DE_spr_DEC, 32'd10);
        idle(1);
        cmp("dec_collide", {32'd0, dec1}, 64'd10);

        // Carry across the word boundary through the prescaler.
        wr(DE_spr_TBL, 32'hFFFF_FFFE);
        wr(DE_spr_TBU, 32'h0000_0001);
        idle(8);

        // Underflow raises dec_irq; ack colliding with a new set keeps it high.
        wr(DE_spr_DEC, 32'd2);
        idle(5);
        wr(DE_spr_DEC, 32'd0);
        step(1'b1, 1'b0, 6'h00, 32'd0, 1'b0, 1'b1);
        idle(1);
        cmp("ack_vs_set_irq", {63'd0, irq1}, 64'd1);

        for (int k = 0; k < 10; k++) step(1'b1, 1'b0, 6'h00, 32'd0, 1'b1, 1'b0);
        idle(3);

        // Asynchronous reset between edges with dec_irq pending.
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        cmp("async_rst_tb", tb1, 64'd0);
        cmp("async_rst_dec", {32'd0, dec4}, 64'hFFFF_FFFF);
        cmp("async_rst_irq", {63'd0, irq1}, 64'd0);
        step(1'b0, 1'b0, 6'h00, 32'd0, 1'b0, 1'b0);
        idle(2);

        wr(DE_spr_DEC, 32'd5);
        wr(DE_spr_DEC, 32'h8000_0000);
        idle(1);
`ifdef TBDEC_MTDEC_IRQ_EN
        irq_exp = 32'd1;
`else
        irq_exp = 32'd0;
`endif
        cmp("mtdec_irq", {63'd0, irq1}, {32'd0, irq_exp});

        for (int k = 0; k < 600; k++) begin
            rst_next = ($urandom_range(0, 99) != 0);
            case ($urandom_range(0, 5))
                0: nm = DE_spr_TBL;
                1: nm = DE_spr_TBU;
                2, 3: nm = DE_spr_DEC;
                default: nm = 6'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0: v = 32'hFFFF_FFFF;
                1: v = 32'hFFFF_FFFE;
                2: v = 32'($urandom_range(0, 3));
                3: v = 32'h8000_0000;
                default: v = $urandom;
            endcase
            step(rst_next, ($urandom_range(0, 3) == 0), nm, v,
                 ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0));
        end
        idle(3);
        @(posedge clk);
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
